// File: rtl/credit_stream_sender_counter.sv
// credit_stream_sender_counter: saturating up/down credit counter with empty and overflow flags.
module credit_stream_sender_counter #(
    parameter int p_max   = 2,
    parameter int p_width = $clog2(p_max + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               decrement,
    input  logic               increment,
    output logic [p_width-1:0] count,
    output logic               zero,
    output logic               overflow
);
    logic full;
    assign full     = count == p_width'(p_max);
    assign zero     = count == '0;
    assign overflow = increment && !decrement && full;
    always_ff @(posedge clk) begin
        if (reset)
            count <= p_width'(p_max);
        else if (decrement && !increment && !zero)
            count <= count - 1'b1;
        else if (increment && !decrement && !full)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/credit_stream_sender.sv
// credit_stream_sender: forwards a val/rdy stream over a valid-only link,
// gated by credits returned from a fixed-depth remote queue.
module credit_stream_sender #(
    parameter int p_msg_nbits   = 32,
    parameter int p_num_credits = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 istream_val,
    output logic                                 istream_rdy,
    input  logic [p_msg_nbits-1:0]               istream_msg,
    output logic                                 ostream_val,
    output logic [p_msg_nbits-1:0]               ostream_msg,
    input  logic                                 credit_return,
    output logic [$clog2(p_num_credits+1)-1:0]   num_credits,
    output logic                                 credit_err
);
    localparam int c_w = $clog2(p_num_credits + 1);
    logic fire, zero, overflow;
    assign fire        = istream_val && istream_rdy;
    assign istream_rdy = !zero;
    credit_stream_sender_counter #(.p_max(p_num_credits), .p_width(c_w)) u_counter (
        .clk       (clk),
        .reset     (reset),
        .decrement (fire),
        .increment (credit_return),
        .count     (num_credits),
        .zero      (zero),
        .overflow  (overflow)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            ostream_val <= 1'b0;
            ostream_msg <= '0;
            credit_err  <= 1'b0;
        end else begin
            ostream_val <= fire;
            if (fire)
                ostream_msg <= istream_msg;
            if (overflow)
                credit_err <= 1'b1;
        end
    end
    a_count_bound: assert property (@(posedge clk) disable iff (reset) num_credits <= c_w'(p_num_credits));
endmodule

// File: tb/tb_credit_stream_sender.sv
// tb_credit_stream_sender: directed credit-flow checks plus an end-to-end run against a two-entry queue model.
module tb_credit_stream_sender;
    logic        clk = 1'b0;
    logic        reset, istream_val, istream_rdy, ostream_val, credit_return, credit_err;
    logic [31:0] istream_msg, ostream_msg;
    logic [1:0]  num_credits;
    int n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;

    credit_stream_sender #(.p_msg_nbits(32), .p_num_credits(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .istream_val   (istream_val),
        .istream_rdy   (istream_rdy),
        .istream_msg   (istream_msg),
        .ostream_val   (ostream_val),
        .ostream_msg   (ostream_msg),
        .credit_return (credit_return),
        .num_credits   (num_credits),
        .credit_err    (credit_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // receiver model: two-entry normal queue, dequeue frees a credit
    logic        e2e = 1'b0;
    logic [31:0] rq[$];
    logic [31:0] exp_q[$];
    int          rx_cnt = 0;
    always @(posedge clk) begin
        if (e2e && !reset) begin
            if (istream_val && istream_rdy)
                exp_q.push_back(istream_msg);
            if (credit_return) begin
                if (exp_q.size() == 0)
                    check("e2e_unexpected_rx", 64'd1, 64'd0);
                else
                    check("e2e_msg", {32'd0, rq[0]}, {32'd0, exp_q.pop_front()});
                rq.pop_front();
                rx_cnt <= rx_cnt + 1;
            end
            if (ostream_val) begin
                if (rq.size() - int'(credit_return) >= 2)
                    check("e2e_rq_overrun", 64'd1, 64'd0);
                rq.push_back(ostream_msg);
            end
        end
    end

    initial begin
        int sent;
        int cyc;
        logic sink_rdy;
        logic [31:0] data [20];
        reset = 1'b1; istream_val = 1'b0; istream_msg = '0; credit_return = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_credits", num_credits, 2);
        check("rst_rdy", istream_rdy, 1);
        check("rst_oval", ostream_val, 0);
        check("rst_omsg", ostream_msg, 0);
        check("rst_err", credit_err, 0);
        // exhaust credits with 0xA, 0xB
        istream_val = 1'b1; istream_msg = 32'hA;
        @(negedge clk);
        check("ex_a_oval", ostream_val, 1);
        check("ex_a_omsg", ostream_msg, 32'hA);
        check("ex_a_credits", num_credits, 1);
        istream_msg = 32'hB;
        @(negedge clk);
        check("ex_b_oval", ostream_val, 1);
        check("ex_b_omsg", ostream_msg, 32'hB);
        check("ex_b_credits", num_credits, 0);
        check("ex_b_rdy", istream_rdy, 0);
        istream_msg = 32'hC;
        repeat (3) begin
            @(negedge clk);
            check("stall_oval", ostream_val, 0);
            check("stall_credits", num_credits, 0);
            check("stall_omsg", ostream_msg, 32'hB);
        end
        // refill from empty: no same-cycle bypass
        credit_return = 1'b1;
        @(negedge clk);
        credit_return = 1'b0;
        check("refill_oval", ostream_val, 0);
        check("refill_credits", num_credits, 1);
        check("refill_rdy", istream_rdy, 1);
        @(negedge clk);
        istream_val = 1'b0;
        check("refill_c_oval", ostream_val, 1);
        check("refill_c_omsg", ostream_msg, 32'hC);
        check("refill_c_credits", num_credits, 0);
        credit_return = 1'b1;
        @(negedge clk);
        check("pre_sim_credits", num_credits, 1);
        // simultaneous fire and credit return
        istream_val = 1'b1; istream_msg = 32'hD;
        @(negedge clk);
        istream_val = 1'b0; credit_return = 1'b0;
        check("sim_credits", num_credits, 1);
        check("sim_oval", ostream_val, 1);
        check("sim_omsg", ostream_msg, 32'hD);
        credit_return = 1'b1;
        @(negedge clk);
        check("pre_ovf_credits", num_credits, 2);
        check("pre_ovf_err", credit_err, 0);
        // overflow: credit returned while full
        @(negedge clk);
        credit_return = 1'b0;
        istream_msg = 'x;
        check("ovf_credits", num_credits, 2);
        check("ovf_err", credit_err, 1);
        repeat (10) begin
            @(negedge clk);
            check("ovf_err_sticky", credit_err, 1);
            check("ovf_x_oval", ostream_val, 0);
            check("ovf_x_omsg", ostream_msg, 32'hD);
        end
        // reset during a fire drops the in-flight message
        istream_val = 1'b1; istream_msg = 32'hE; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; istream_val = 1'b0;
        check("mid_rst_oval", ostream_val, 0);
        check("mid_rst_credits", num_credits, 2);
        check("mid_rst_err", credit_err, 0);
        check("mid_rst_omsg", ostream_msg, 0);
        // end-to-end against the receiver queue model
        foreach (data[i]) data[i] = $urandom;
        sent = 0; cyc = 0;
        e2e = 1'b1;
        while (rx_cnt < 20 && cyc < 2000) begin
            sink_rdy      = $urandom_range(0, 2) != 0;
            credit_return = sink_rdy && rq.size() > 0;
            istream_val   = sent < 20 && $urandom_range(0, 3) != 0;
            istream_msg   = sent < 20 ? data[sent] : 'x;
            check("e2e_invariant", 64'(num_credits) + 64'(ostream_val) + 64'(rq.size()), 2);
            check("e2e_err", credit_err, 0);
            if (istream_val && istream_rdy)
                sent++;
            @(negedge clk);
            cyc++;
        end
        istream_val = 1'b0; credit_return = 1'b0;
        check("e2e_rx_count", 64'(rx_cnt), 20);
        check("e2e_exp_empty", 64'(exp_q.size()), 0);
        check("e2e_final_err", credit_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
